// File: rtl/ex_branch_resolve.sv
// rtl/ex_branch_resolve.sv - execute-stage branch resolution with wrong-path squash and perf counters
// One-cycle registered resolve; a mispredict kills the next SQUASH_CYCLES accepted cycles.
module ex_branch_resolve #(
   parameter int SQUASH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        is_branch_i,
   input  logic        is_jump_i,
   input  logic [2:0]  funct3_i,
   input  logic        predicted_taken_i,
   input  logic [31:0] alu_result_i,
   input  logic        neg_flag_i,
   input  logic        zero_flag_i,
   input  logic        carry_flag_i,
   input  logic        v_flag_i,
   input  logic [31:0] pc_target_i,
   input  logic [31:0] pc_plus4_i,
   output logic        valid_o,
   output logic [31:0] alu_result_o,
   output logic        taken_o,
   output logic        mispredict_o,
   output logic [31:0] redirect_pc_o,
   output logic        squash_o,
   output logic [31:0] branch_count_o,
   output logic [31:0] mispredict_count_o
);

   localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYCLES);

   typedef enum logic {
      IDLE,
      SQUASH
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sq_cnt_q, sq_cnt_d;
   logic        valid_q, valid_d;
   logic        taken_q, taken_d;
   logic        misp_q, misp_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] redirect_q, redirect_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mp_cnt_q, mp_cnt_d;

   logic cond_taken;
   logic taken;
   logic mispredict;
   logic accept;

   // Carry set means "no borrow", so BLTU is taken on !carry and BGEU on carry.
   always_comb begin
      cond_taken = 1'b0;
      case (funct3_i)
         3'b000:  cond_taken = zero_flag_i;
         3'b001:  cond_taken = !zero_flag_i;
         3'b100:  cond_taken = neg_flag_i ^ v_flag_i;
         3'b101:  cond_taken = !(neg_flag_i ^ v_flag_i);
         3'b110:  cond_taken = !carry_flag_i;
         3'b111:  cond_taken = carry_flag_i;
         default: cond_taken = 1'b0;
      endcase
   end

   assign taken      = is_jump_i ? 1'b1 : (is_branch_i ? cond_taken : 1'b0);
   assign mispredict = (is_branch_i | is_jump_i) & (taken != predicted_taken_i);
   assign accept     = valid_i & ~stall_i & ~flush_i & (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      sq_cnt_d   = sq_cnt_q;
      valid_d    = valid_q;
      taken_d    = taken_q;
      misp_d     = misp_q;
      alu_d      = alu_q;
      redirect_d = redirect_q;
      br_cnt_d   = br_cnt_q;
      mp_cnt_d   = mp_cnt_q;

      if (flush_i) begin
         valid_d  = 1'b0;
         taken_d  = 1'b0;
         misp_d   = 1'b0;
         state_d  = IDLE;
         sq_cnt_d = 2'd0;
      end else if (!stall_i) begin
         valid_d = 1'b0;
         taken_d = 1'b0;
         misp_d  = 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  valid_d    = 1'b1;
                  taken_d    = taken;
                  misp_d     = mispredict;
                  alu_d      = alu_result_i;
                  redirect_d = taken ? pc_target_i : pc_plus4_i;
                  if (is_branch_i && !is_jump_i && (br_cnt_q != 32'hFFFF_FFFF))
                     br_cnt_d = br_cnt_q + 32'd1;
                  if (mispredict && (mp_cnt_q != 32'hFFFF_FFFF))
                     mp_cnt_d = mp_cnt_q + 32'd1;
                  if (mispredict) begin
                     state_d  = SQUASH;
                     sq_cnt_d = SQ_LOAD;
                  end
               end
            end
            SQUASH: begin
               // Wrong-path inputs are dropped; leave once the count runs out.
               if (sq_cnt_q <= 2'd1) begin
                  state_d  = IDLE;
                  sq_cnt_d = 2'd0;
               end else begin
                  sq_cnt_d = sq_cnt_q - 2'd1;
               end
            end
            default: begin
               state_d  = IDLE;
               sq_cnt_d = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sq_cnt_q   <= 2'd0;
         valid_q    <= 1'b0;
         taken_q    <= 1'b0;
         misp_q     <= 1'b0;
         alu_q      <= 32'd0;
         redirect_q <= 32'd0;
         br_cnt_q   <= 32'd0;
         mp_cnt_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         sq_cnt_q   <= sq_cnt_d;
         valid_q    <= valid_d;
         taken_q    <= taken_d;
         misp_q     <= misp_d;
         alu_q      <= alu_d;
         redirect_q <= redirect_d;
         br_cnt_q   <= br_cnt_d;
         mp_cnt_q   <= mp_cnt_d;
      end
   end

   assign valid_o            = valid_q;
   assign alu_result_o       = alu_q;
   assign taken_o            = taken_q;
   assign mispredict_o       = misp_q;
   assign redirect_pc_o      = redirect_q;
   assign squash_o           = (state_q == SQUASH);
   assign branch_count_o     = br_cnt_q;
   assign mispredict_count_o = mp_cnt_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb/tb_ex_branch_resolve.sv - directed self-checking bench for ex_branch_resolve
module tb_ex_branch_resolve;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        is_branch_i = 1'b0;
   logic        is_jump_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic        predicted_taken_i = 1'b0;
   logic [31:0] alu_result_i = 32'd0;
   logic        neg_flag_i = 1'b0;
   logic        zero_flag_i = 1'b0;
   logic        carry_flag_i = 1'b0;
   logic        v_flag_i = 1'b0;
   logic [31:0] pc_target_i = 32'd0;
   logic [31:0] pc_plus4_i = 32'd0;
   logic        valid_o;
   logic [31:0] alu_result_o;
   logic        taken_o;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;
   logic        squash_o;
   logic [31:0] branch_count_o;
   logic [31:0] mispredict_count_o;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ex_branch_resolve #(.SQUASH_CYCLES(2)) dut (
      .clk                (clk),
      .reset              (reset),
      .valid_i            (valid_i),
      .stall_i            (stall_i),
      .flush_i            (flush_i),
      .is_branch_i        (is_branch_i),
      .is_jump_i          (is_jump_i),
      .funct3_i           (funct3_i),
      .predicted_taken_i  (predicted_taken_i),
      .alu_result_i       (alu_result_i),
      .neg_flag_i         (neg_flag_i),
      .zero_flag_i        (zero_flag_i),
      .carry_flag_i       (carry_flag_i),
      .v_flag_i           (v_flag_i),
      .pc_target_i        (pc_target_i),
      .pc_plus4_i         (pc_plus4_i),
      .valid_o            (valid_o),
      .alu_result_o       (alu_result_o),
      .taken_o            (taken_o),
      .mispredict_o       (mispredict_o),
      .redirect_pc_o      (redirect_pc_o),
      .squash_o           (squash_o),
      .branch_count_o     (branch_count_o),
      .mispredict_count_o (mispredict_count_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // nzcv = {neg, zero, carry, v}
   task automatic drive(input logic br, input logic jmp, input logic [2:0] f3, input logic pred,
                        input logic [3:0] nzcv, input logic [31:0] tgt, input logic [31:0] p4,
                        input logic [31:0] alu);
      valid_i           = 1'b1;
      is_branch_i       = br;
      is_jump_i         = jmp;
      funct3_i          = f3;
      predicted_taken_i = pred;
      neg_flag_i        = nzcv[3];
      zero_flag_i       = nzcv[2];
      carry_flag_i      = nzcv[1];
      v_flag_i          = nzcv[0];
      pc_target_i       = tgt;
      pc_plus4_i        = p4;
      alu_result_i      = alu;
   endtask

   task automatic idle();
      valid_i     = 1'b0;
      is_branch_i = 1'b0;
      is_jump_i   = 1'b0;
   endtask

   task automatic check_ctl(input string tag, input logic v, input logic t, input logic m,
                            input logic sq);
      check_eq({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
      check_eq({tag, ".taken"}, {31'd0, taken_o}, {31'd0, t});
      check_eq({tag, ".misp"}, {31'd0, mispredict_o}, {31'd0, m});
      check_eq({tag, ".squash"}, {31'd0, squash_o}, {31'd0, sq});
   endtask

   task automatic check_cnt(input string tag, input logic [31:0] br, input logic [31:0] mp);
      check_eq({tag, ".br_cnt"}, branch_count_o, br);
      check_eq({tag, ".mp_cnt"}, mispredict_count_o, mp);
   endtask

   typedef struct {
      logic       br;
      logic       jmp;
      logic [2:0] f3;
      logic [3:0] nzcv;
      logic       exp_taken;
      logic [31:0] exp_br;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 3'b001, 4'b0000, 1'b1, 32'd4};
      vecs[1] = '{1'b1, 1'b0, 3'b001, 4'b0100, 1'b0, 32'd5};
      vecs[2] = '{1'b1, 1'b0, 3'b101, 4'b1000, 1'b0, 32'd6};
      vecs[3] = '{1'b1, 1'b0, 3'b101, 4'b1001, 1'b1, 32'd7};
      vecs[4] = '{1'b1, 1'b0, 3'b111, 4'b0010, 1'b1, 32'd8};
      vecs[5] = '{1'b1, 1'b0, 3'b110, 4'b0010, 1'b0, 32'd9};
      vecs[6] = '{1'b1, 1'b0, 3'b010, 4'b0100, 1'b0, 32'd10};
      vecs[7] = '{1'b1, 1'b0, 3'b011, 4'b1111, 1'b0, 32'd11};
      vecs[8] = '{1'b1, 1'b1, 3'b000, 4'b0000, 1'b1, 32'd11};
      vecs[9] = '{1'b0, 1'b0, 3'b000, 4'b0100, 1'b0, 32'd11};

      #2 reset = 1'b1;
      #2;
      check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst.redirect", redirect_pc_o, 32'd0);
      check_eq("rst.alu", alu_result_o, 32'd0);
      check_cnt("rst", 32'd0, 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;

      // BEQ taken, predicted not taken
      drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0100, 32'h100, 32'h44, 32'h11);
      step();
      check_ctl("beq", 1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("beq.redirect", redirect_pc_o, 32'h100);
      check_eq("beq.alu", alu_result_o, 32'h11);
      check_cnt("beq", 32'd1, 32'd1);
      step();
      check_ctl("beq.kill1", 1'b0, 1'b0, 1'b0, 1'b1);
      check_cnt("beq.kill1", 32'd1, 32'd1);
      step();
      check_ctl("beq.kill2", 1'b0, 1'b0, 1'b0, 1'b0);
      check_cnt("beq.kill2", 32'd1, 32'd1);

      // BLTU taken, correctly predicted
      drive(1'b1, 1'b0, 3'b110, 1'b1, 4'b0000, 32'h200, 32'h48, 32'h0);
      step();
      check_ctl("bltu", 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("bltu.redirect", redirect_pc_o, 32'h200);
      check_cnt("bltu", 32'd2, 32'd1);

      // BLT not taken (neg^v=0), predicted taken
      drive(1'b1, 1'b0, 3'b100, 1'b1, 4'b1001, 32'h300, 32'h4C, 32'h0);
      step();
      check_ctl("blt", 1'b1, 1'b0, 1'b1, 1'b1);
      check_eq("blt.redirect", redirect_pc_o, 32'h4C);
      check_cnt("blt", 32'd3, 32'd2);
      drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0100, 32'h310, 32'h50, 32'h0);
      step();
      check_ctl("blt.kill1", 1'b0, 1'b0, 1'b0, 1'b1);
      check_cnt("blt.kill1", 32'd3, 32'd2);
      step();
      check_ctl("blt.kill2", 1'b0, 1'b0, 1'b0, 1'b0);
      check_cnt("blt.kill2", 32'd3, 32'd2);

      // Condition table, all correctly predicted
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].br, vecs[i].jmp, vecs[i].f3, vecs[i].exp_taken, vecs[i].nzcv,
               32'h1000 + 32'(i * 8), 32'h2000 + 32'(i * 8), 32'(i));
         step();
         check_ctl($sformatf("vec%0d", i), 1'b1, vecs[i].exp_taken, 1'b0, 1'b0);
         check_eq($sformatf("vec%0d.redirect", i), redirect_pc_o,
                  vecs[i].exp_taken ? 32'h1000 + 32'(i * 8) : 32'h2000 + 32'(i * 8));
         check_cnt($sformatf("vec%0d", i), vecs[i].exp_br, 32'd2);
      end

      // Jump mispredicted: counts a mispredict but not a branch
      drive(1'b0, 1'b1, 3'b001, 1'b0, 4'b0100, 32'h500, 32'h60, 32'h0);
      step();
      check_ctl("jmp", 1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("jmp.redirect", redirect_pc_o, 32'h500);
      check_cnt("jmp", 32'd11, 32'd3);
      idle();
      step();
      check_ctl("jmp.kill1", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check_ctl("jmp.kill2", 1'b0, 1'b0, 1'b0, 1'b0);

      // Stall holds, then stall+flush clears
      drive(1'b1, 1'b0, 3'b000, 1'b1, 4'b0100, 32'h600, 32'h64, 32'hABCD);
      step();
      check_ctl("stl.acc", 1'b1, 1'b1, 1'b0, 1'b0);
      check_cnt("stl.acc", 32'd12, 32'd3);
      stall_i = 1'b1;
      drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0100, 32'h700, 32'h68, 32'h1111);
      for (int i = 0; i < 3; i++) begin
         step();
         check_ctl($sformatf("stl%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
         check_eq($sformatf("stl%0d.alu", i), alu_result_o, 32'hABCD);
         check_eq($sformatf("stl%0d.redirect", i), redirect_pc_o, 32'h600);
         check_cnt($sformatf("stl%0d", i), 32'd12, 32'd3);
      end
      flush_i = 1'b1;
      step();
      check_ctl("flush", 1'b0, 1'b0, 1'b0, 1'b0);
      check_cnt("flush", 32'd12, 32'd3);
      stall_i = 1'b0;
      flush_i = 1'b0;
      idle();

      // Saturation
      force dut.br_cnt_q = 32'hFFFF_FFFE;
      force dut.mp_cnt_q = 32'hFFFF_FFFE;
      step();
      release dut.br_cnt_q;
      release dut.mp_cnt_q;
      step();
      check_cnt("preload", 32'hFFFF_FFFE, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 3'b000, 1'b1, 4'b0100, 32'h700, 32'h70, 32'h0);
         step();
         check_cnt($sformatf("sat%0d", i), 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      end
      drive(1'b1, 1'b0, 3'b000, 1'b0, 4'b0100, 32'h700, 32'h70, 32'h0);
      step();
      check_ctl("sat.misp", 1'b1, 1'b1, 1'b1, 1'b1);
      check_cnt("sat.misp", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Asynchronous reset during squash
      idle();
      #2 reset = 1'b1;
      #1;
      check_ctl("arst", 1'b0, 1'b0, 1'b0, 1'b0);
      check_cnt("arst", 32'd0, 32'd0);
      #2 reset = 1'b0;
      drive(1'b1, 1'b0, 3'b000, 1'b1, 4'b0100, 32'h800, 32'h74, 32'h5);
      step();
      check_ctl("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("post_rst.redirect", redirect_pc_o, 32'h800);
      check_cnt("post_rst", 32'd1, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
